// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and the coefficient type.
// Imported by the coefficient FIFO and its storage array.
package ntt_pkg;

    localparam int COEF_WIDTH      = 14;
    localparam int Q               = 12289;
    localparam int FIFO_ADDR_WIDTH = 3;

    typedef logic [COEF_WIDTH-1:0] coef_t;

endpackage

// File: rtl/coef_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Ports: clk; we/waddr/wdata write port; re/raddr read port;
//        rdata holds the word read on the last re edge. No reset.
module coef_fifo_mem
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/coef_stream_fifo.sv
// Coefficient FIFO between the butterfly array and memory write-back.
// Ports: clk, rst (sync, active-low); wr_en/wr_data/full write side;
//        rd_en/rd_data/rd_valid/empty read side; count fill level;
//        ovf/udf sticky error flags cleared by clr_err.
module coef_stream_fifo
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_err
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_seen;
    logic [DATA_WIDTH-1:0] mem_q;

    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        count  = wr_ptr - rd_ptr;
        // Storage ports are blocked during reset so reset wins outright.
        wr_acc = wr_en & ~full & rst;
        rd_acc = rd_en & ~empty & rst;
        // The array read register has no reset; rd_seen masks it to zero
        // until the first accepted read after reset.
        rd_data = rd_seen ? mem_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_seen  <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + PW'(1);
                rd_seen <= 1'b1;
            end
            rd_valid <= rd_acc;
            // A new error event beats a same-cycle clear.
            ovf <= (wr_en & full) | (ovf & ~clr_err);
            udf <= (rd_en & empty) | (udf & ~clr_err);
        end
    end

    coef_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_q)
    );

endmodule

// File: doc/coef_stream_fifo.md
Name: coef_stream_fifo

Overview:
- Synchronous FIFO that receives 14-bit NTT coefficients from the radix-2 butterfly array and hands them to the memory write-back path.
- Acts as the reader-side counterpart to the butterfly output registers. It absorbs bursts from the 4-BFU pipeline and releases them with a registered read port.
- Single clock domain, with overflow and underflow tracking for debug.

Parameters:
- DATA_WIDTH, 14, coefficient width (q = 12289 fits in 14 bits).
- ADDR_WIDTH, 3, log2 of depth; depth = 2**ADDR_WIDTH = 8 entries.

Ports:
- clk  in  1  system clock; all logic samples on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request from the butterfly side.
- wr_data  in  DATA_WIDTH  coefficient to store.
- full  out  1  no free entries; combinational from the pointers.
- rd_en  in  1  read request from the write-back side.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data holds a newly read word this cycle.
- empty  out  1  no stored entries; combinational from the pointers.
- count  out  ADDR_WIDTH+1  number of stored entries, 0..2**ADDR_WIDTH.
- ovf  out  1  sticky flag: a write was attempted while full.
- udf  out  1  sticky flag: a read was attempted while empty.
- clr_err  in  1  clears ovf and udf.

Behaviour:
- Reset: rst is synchronous and active-low; rst sampled low at a rising edge of clk resets the block.
  - Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, rd_data = 0, rd_valid = 0, ovf = 0, udf = 0.
  - Storage array is not reset.
  - Reset mid-burst discards all contents. Reset has priority over every other input.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address storage; the MSB is the wrap bit.
  - empty when wr_ptr == rd_ptr.
  - full when the MSBs differ and the low bits are equal.
- Write accept: wr_acc = wr_en & ~full, using full as sampled at the start of the cycle.
  - On accept: mem[wr_ptr low bits] <= wr_data, and wr_ptr increments modulo 2**(ADDR_WIDTH+1).
- Read accept: rd_acc = rd_en & ~empty, using empty as sampled at the start of the cycle.
  - On accept: rd_data <= mem[rd_ptr low bits] and rd_ptr increments; rd_valid = 1 in the next cycle.
- Read latency: exactly 1 clock from the rd_en edge to the rd_valid/rd_data cycle.
  - When no read is accepted, rd_valid = 0 and rd_data holds its previous value.
- Simultaneous write and read:
  - Both neither full nor empty: both are accepted and count is unchanged.
  - When full: the read is accepted and the write is rejected (ovf is set). No write-through.
  - When empty: the write is accepted and the read is rejected (udf is set). No read-through; the written word is readable from the next cycle.
- count: next count = count + wr_acc − rd_acc; it is never negative and never above 2**ADDR_WIDTH.
- Error flags:
  - ovf sets on wr_en & full; udf sets on rd_en & empty.
  - Both hold until clr_err = 1 or reset. If a set and clr_err occur in the same cycle, the set wins.
- Wrap-around: pointers roll over silently with no bubble; data order is strictly FIFO.
- Rejected operations change no state other than the sticky flags.

Decomposition:
- Shared package ntt_pkg holds:
  - COEF_WIDTH = 14 and Q = 12289;
  - FIFO_ADDR_WIDTH default = 3;
  - a coef_t typedef of COEF_WIDTH bits.
- One sub-module, coef_fifo_mem: a simple dual-port register array with a synchronous write and a registered read, no reset.
- Pointer, flag and count logic stays in the top module.

Test Plan:
- Reset then idle: after rst is held low for 2 cycles and released → empty = 1, full = 0, count = 0, rd_valid = 0, rd_data = 0, ovf = udf = 0.
- Fill and drain: write 1, 2, …, 8 on consecutive cycles → full = 1 and count = 8 after the 8th edge. Then hold rd_en for 8 cycles → rd_data = 1..8 in order, each with rd_valid = 1 one cycle after the request; empty = 1 at the end.
- Overflow: with the FIFO full, assert wr_en with wr_data = 12288 → ovf = 1, count stays 8, and a full drain returns no 12288.
  - Then assert clr_err → ovf = 0.
- Underflow and same-cycle write on empty: assert wr_en (data 5) and rd_en together while empty → udf = 1, count = 1, rd_valid = 0. Next cycle a read returns 5 with rd_valid = 1.
- Streaming wrap-around: with count held at 3, write and read every cycle for 20 cycles (data 100..119) → count stays 3, output order is exactly 100, 101, … with no gaps, and both pointers wrap at least twice.
- Reset mid-operation: with count = 5, pull rst low for 1 cycle together with wr_en = rd_en = 1 → count = 0, empty = 1, rd_valid = 0 in the following cycle, and no stale data is returned after release.
